// File: rtl/spi_master_param_if.sv
// Load/result interface between the packet formatter and spi_master_param.
//   in_valid / in_ready : valid/ready handshake for one word to transmit
//   in_data             : word to transmit, latched at the handshake
//   busy                : transaction in progress
//   done                : one-cycle pulse when a transaction completes
//   rx_data             : word received on miso, updated with done
// Modports: master = word producer, slave = SPI master block.
interface spi_master_param_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] rx_data;

  modport master (
    output in_valid, in_data,
    input  in_ready, busy, done, rx_data
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, busy, done, rx_data
  );
endinterface

// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master, one DATA_WIDTH word per transaction.
// Ports:
//   clk, reset     : system clock, synchronous active-high reset
//   bus (slave)    : in_valid/in_ready/in_data load handshake, busy, done, rx_data
//   miso           : serial data from slave
//   sclk, mosi     : SPI clock and data to slave (registered)
//   cs_n           : active-low chip select (registered)
// Optional build macro SPI_MASTER_RX_EN: when defined, miso is sampled into an
// rx shift register and presented on rx_data at done; otherwise rx_data is 0.
module spi_master_param #(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV    = 2,
  parameter int CPOL       = 0,
  parameter int CPHA       = 0,
  parameter int MSB_FIRST  = 1
) (
  input  logic                clk,
  input  logic                reset,
  spi_master_param_if.slave   bus,
  input  logic                miso,
  output logic                sclk,
  output logic                mosi,
  output logic                cs_n
);

  localparam int DIVW = $clog2(CLK_DIV + 1);
  localparam int CW   = $clog2(DATA_WIDTH + 1);
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);
  localparam logic            IDLE_LVL = 1'(CPOL);
  // Sample count already reached when the final trailing edge arrives.
  localparam logic [CW-1:0]   LAST_CNT = (CPHA != 0) ? CW'(DATA_WIDTH - 1) : CW'(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t                state_q, state_d;
  logic [DIVW-1:0]       div_q;
  logic [CW-1:0]         bit_cnt_q;
  logic [DATA_WIDTH-1:0] tx_sr;
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic                  sclk_q, mosi_q, cs_n_q, done_q;
  logic                  cs_n_d, done_d;
  logic                  in_ready, handshake;
  logic                  half_tick, edge_now, lead_edge, trail_edge;
  logic                  sample_edge, shift_edge, last_edge;

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[DATA_WIDTH-1] : w[0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? {w[DATA_WIDTH-2:0], 1'b0} : {1'b0, w[DATA_WIDTH-1:1]};
  endfunction

  assign in_ready  = (state_q == IDLE) && !reset;
  assign handshake = bus.in_valid && in_ready;

  // Each SCLK toggle is scheduled on a half-period boundary inside XFER, so the
  // 2*DATA_WIDTH-th toggle lands on the XFER->HOLD transition.
  assign half_tick   = (state_q != IDLE) && (div_q == DIV_LAST);
  assign edge_now    = (state_q == XFER) && half_tick;
  assign lead_edge   = edge_now && (sclk_q == IDLE_LVL);
  assign trail_edge  = edge_now && (sclk_q != IDLE_LVL);
  assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
  assign shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;
  assign last_edge   = trail_edge && (bit_cnt_q == LAST_CNT);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (handshake) state_d = SETUP;
      SETUP:   if (half_tick) state_d = XFER;
      XFER:    if (last_edge) state_d = HOLD;
      HOLD:    if (half_tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cs_n_d = (state_d == IDLE);
    done_d = (state_q == HOLD) && (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q     <= '0;
      bit_cnt_q <= '0;
      tx_sr     <= '0;
      sclk_q    <= IDLE_LVL;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      cs_n_q <= cs_n_d;
      done_q <= done_d;

      if (state_q == IDLE || half_tick) div_q <= '0;
      else                              div_q <= div_q + DIVW'(1);

      if (state_q == IDLE)  bit_cnt_q <= '0;
      else if (sample_edge) bit_cnt_q <= bit_cnt_q + CW'(1);

      if (edge_now) sclk_q <= ~sclk_q;

      if (handshake) begin
        tx_sr <= bus.in_data;
        if (CPHA == 0) mosi_q <= first_bit(bus.in_data);
      end else if (shift_edge && !last_edge) begin
        tx_sr <= shift_out(tx_sr);
        // CPHA=1 drives the current bit on the leading edge; CPHA=0 has already
        // presented it, so it moves on to the following bit.
        if (CPHA != 0) mosi_q <= first_bit(tx_sr);
        else           mosi_q <= first_bit(shift_out(tx_sr));
      end
    end
  end

`ifdef SPI_MASTER_RX_EN
  logic [DATA_WIDTH-1:0] rx_sr;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sr     <= '0;
      rx_data_q <= '0;
    end else begin
      if (sample_edge) begin
        if (MSB_FIRST != 0) rx_sr <= {rx_sr[DATA_WIDTH-2:0], miso};
        else                rx_sr <= {miso, rx_sr[DATA_WIDTH-1:1]};
      end
      if (done_d) rx_data_q <= rx_sr;
    end
  end
`else
  logic unused_miso;
  assign unused_miso = miso;
  assign rx_data_q   = '0;
`endif

  assign sclk         = sclk_q;
  assign mosi         = mosi_q;
  assign cs_n         = cs_n_q;
  assign bus.in_ready = in_ready;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.rx_data  = rx_data_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: instance A (mode 0, CLK_DIV=2, MSB first, random
// miso) and instance B (mode 3, CLK_DIV=1, LSB first, miso looped to mosi).
module tb_spi_master_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_a, rst_b;
  logic miso_a, sclk_a, mosi_a, cs_n_a;
  logic miso_b, sclk_b, mosi_b, cs_n_b;

  spi_master_param_if #(.DATA_WIDTH(16)) bus_a ();
  spi_master_param_if #(.DATA_WIDTH(16)) bus_b ();

  spi_master_param #(.DATA_WIDTH(16), .CLK_DIV(2), .CPOL(0), .CPHA(0), .MSB_FIRST(1)) dut_a (
    .clk(clk), .reset(rst_a), .bus(bus_a), .miso(miso_a),
    .sclk(sclk_a), .mosi(mosi_a), .cs_n(cs_n_a)
  );

  spi_master_param #(.DATA_WIDTH(16), .CLK_DIV(1), .CPOL(1), .CPHA(1), .MSB_FIRST(0)) dut_b (
    .clk(clk), .reset(rst_b), .bus(bus_b), .miso(miso_b),
    .sclk(sclk_b), .mosi(mosi_b), .cs_n(cs_n_b)
  );

  assign miso_b = mosi_b;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];

  // Random miso for A, changed just after each clock edge.
  initial begin
    miso_a = 1'b0;
    forever begin
      @(posedge clk);
      #1 miso_a = 1'($urandom_range(0, 1));
    end
  end

  // Monitor A: collect mosi/miso at visible sclk rises, check at done.
  logic        pa_sclk = 1'b0, pa_miso = 1'b0, act_a = 1'b0;
  logic [15:0] wa_tx = '0, wa_rx = '0, ew_a;
  int          na = 0, t_hs_a = 0, low_a = 0, done_cnt_a = 0;

  always @(negedge clk) begin
    if (rst_a) begin
      act_a = 1'b0; na = 0; wa_tx = '0; wa_rx = '0;
    end else begin
      if (act_a && !cs_n_a) low_a++;
      if (sclk_a && !pa_sclk) begin
        wa_tx = {wa_tx[14:0], mosi_a};
        wa_rx = {wa_rx[14:0], pa_miso};
        na++;
      end
      if (bus_a.done) begin
        done_cnt_a++;
        check("a_done_expected", 32'(exp_a.size() != 0), 1);
        if (exp_a.size() != 0) begin
          ew_a = exp_a.pop_front();
          check("a_mosi_word", wa_tx, ew_a);
        end
        check("a_rise_count", na, 16);
        check("a_done_latency", cyc - t_hs_a, 69);
        check("a_cs_low_cycles", low_a, 68);
        check("a_cs_high_at_done", cs_n_a, 1);
`ifdef SPI_MASTER_RX_EN
        check("a_rx_data", bus_a.rx_data, wa_rx);
`else
        check("a_rx_data", bus_a.rx_data, 0);
`endif
        na = 0; act_a = 1'b0; wa_tx = '0; wa_rx = '0;
      end
      if (bus_a.in_valid && bus_a.in_ready) begin
        act_a = 1'b1; t_hs_a = cyc; low_a = 0;
      end
    end
    pa_sclk = sclk_a;
    pa_miso = miso_a;
  end

  // Monitor B: LSB-first assembly, miso is the looped-back mosi.
  logic        pb_sclk = 1'b1, act_b = 1'b0;
  logic [15:0] wb_tx = '0, ew_b;
  int          nb = 0, t_hs_b = 0, low_b = 0;

  always @(negedge clk) begin
    if (rst_b) begin
      act_b = 1'b0; nb = 0; wb_tx = '0;
    end else begin
      if (act_b && !cs_n_b) low_b++;
      if (sclk_b && !pb_sclk) begin
        wb_tx = {mosi_b, wb_tx[15:1]};
        nb++;
      end
      if (bus_b.done) begin
        check("b_done_expected", 32'(exp_b.size() != 0), 1);
        if (exp_b.size() != 0) begin
          ew_b = exp_b.pop_front();
          check("b_mosi_word", wb_tx, ew_b);
`ifdef SPI_MASTER_RX_EN
          check("b_rx_data", bus_b.rx_data, ew_b);
`else
          check("b_rx_data", bus_b.rx_data, 0);
`endif
        end
        check("b_rise_count", nb, 16);
        check("b_done_latency", cyc - t_hs_b, 35);
        check("b_cs_low_cycles", low_b, 34);
        check("b_sclk_idle_at_done", sclk_b, 1);
        nb = 0; act_b = 1'b0; wb_tx = '0;
      end
      if (bus_b.in_valid && bus_b.in_ready) begin
        act_b = 1'b1; t_hs_b = cyc; low_b = 0;
      end
    end
    pb_sclk = sclk_b;
  end

  task automatic send_a(input logic [15:0] w);
    bit ok;
    @(posedge clk);
    #1 bus_a.in_valid = 1'b1;
    bus_a.in_data = w;
    exp_a.push_back(w);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus_a.in_ready) begin ok = 1'b1; break; end
    end
    check("a_handshake", ok, 1);
    @(posedge clk);
    #1 bus_a.in_valid = 1'b0;
    bus_a.in_data = 16'($urandom);
  endtask

  task automatic send_b(input logic [15:0] w);
    bit ok;
    @(posedge clk);
    #1 bus_b.in_valid = 1'b1;
    bus_b.in_data = w;
    exp_b.push_back(w);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus_b.in_ready) begin ok = 1'b1; break; end
    end
    check("b_handshake", ok, 1);
    @(posedge clk);
    #1 bus_b.in_valid = 1'b0;
    bus_b.in_data = 16'($urandom);
  endtask

  task automatic drain_a();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_a.size() == 0) break;
    end
    check("a_drain", exp_a.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic drain_b();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_b.size() == 0) break;
    end
    check("b_drain", exp_b.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    bit          ok;
    bit          prev;
    logic        last_cs;
    int          rises;
    int          dc;

    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.in_data = '0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0;
    repeat (3) @(posedge clk);

    // Reset state.
    @(negedge clk);
    check("a_rst_in_ready", bus_a.in_ready, 0);
    check("a_rst_cs_n", cs_n_a, 1);
    check("a_rst_sclk", sclk_a, 0);
    check("a_rst_mosi", mosi_a, 0);
    check("a_rst_busy", bus_a.busy, 0);
    check("a_rst_done", bus_a.done, 0);
    check("a_rst_rx_data", bus_a.rx_data, 0);
    check("b_rst_cs_n", cs_n_b, 1);
    check("b_rst_sclk", sclk_b, 1);
    check("b_rst_in_ready", bus_b.in_ready, 0);
    @(posedge clk);
    #1 rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    check("a_idle_in_ready", bus_a.in_ready, 1);
    check("b_idle_in_ready", bus_b.in_ready, 1);

    // Mode 0 word, then a random word; miso is random throughout.
    send_a(16'hA55A);
    drain_a();
    send_a(16'($urandom));
    drain_a();

    // Reset after the 5th sclk rising edge.
    send_a(16'hF0F0);
    rises = 0;
    prev  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sclk_a && !prev) rises++;
      prev = sclk_a;
      if (rises == 5) break;
    end
    check("a_five_rises", rises, 5);
    dc = done_cnt_a;
    @(posedge clk);
    #1 rst_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("a_midrst_cs_n", cs_n_a, 1);
    check("a_midrst_sclk", sclk_a, 0);
    check("a_midrst_busy", bus_a.busy, 0);
    check("a_midrst_in_ready", bus_a.in_ready, 0);
    exp_a.delete();
    @(posedge clk);
    #1 rst_a = 1'b0;
    @(negedge clk);
    check("a_postrst_in_ready", bus_a.in_ready, 1);
    repeat (80) @(negedge clk);
    check("a_no_done_after_reset", done_cnt_a, dc);
    send_a(16'h00FF);
    drain_a();

    // B: back-to-back words with in_valid held high.
    @(negedge clk);
    check("b_sclk_idle_before", sclk_b, 1);
    @(posedge clk);
    #1 bus_b.in_valid = 1'b1;
    bus_b.in_data = 16'h0001;
    exp_b.push_back(16'h0001);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus_b.in_ready) begin ok = 1'b1; break; end
    end
    check("b_hs1", ok, 1);
    @(posedge clk);
    #1 bus_b.in_data = 16'h8000;
    exp_b.push_back(16'h8000);
    ok = 1'b0;
    last_cs = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus_b.in_ready) begin ok = 1'b1; break; end
      last_cs = cs_n_b;
    end
    check("b_hs2", ok, 1);
    check("b_hs2_in_done_cycle", bus_b.done, 1);
    check("b_gap_cs_high", cs_n_b, 1);
    check("b_cs_low_before_gap", last_cs, 0);
    @(posedge clk);
    #1 bus_b.in_valid = 1'b0;
    @(negedge clk);
    check("b_cs_low_after_gap", cs_n_b, 0);
    drain_b();

    // Mode 3 loopback word and LSB-first 0x0003.
    send_b(16'h3C81);
    drain_b();
    send_b(16'h0003);
    drain_b();
    check("b_sclk_idle_after", sclk_b, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
